// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: decodes the fetched word, reads rs1/rs2 from a
// 32x32 register file with writeback bypass, and hands a registered bundle to execute.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_instr_type,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rrs1,
  output logic [XLEN-1:0] out_rrs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] ins, input logic legal);
    logic signed [XLEN-1:0] imm;
    logic [4:0] opc;
    logic [2:0] f3;
    opc = ins[6:2];
    f3  = ins[14:12];
    imm = '0;
    if (legal) begin
      case (opc)
        OPC_LOAD, OPC_JALR: imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
        OPC_OP_IMM:
          if (f3 == 3'b001 || f3 == 3'b101) imm = {{(XLEN-5){1'b0}}, ins[24:20]};
          else                              imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
        OPC_STORE:  imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
        OPC_BRANCH: imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        OPC_LUI, OPC_AUIPC: imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
        OPC_JAL:    imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        default:    imm = '0;
      endcase
    end
    return imm;
  endfunction

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wr_en;

  logic            valid_q, valid_d;
  logic [4:0]      type_q, type_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [XLEN-1:0] rrs1_q, rrs1_d;
  logic [XLEN-1:0] rrs2_q, rrs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;

  logic [4:0]      opc, rs1, rs2;
  logic [2:0]      f3;
  logic            legal, is_shift, accept;
  logic [XLEN-1:0] op1, op2;

  assign wr_en    = wb_en && (wb_rd != 5'd0);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wb_rd] = wb_data;
  end

  // Decode and bypassed operand read for the incoming instruction
  always_comb begin
    opc = in_instr[6:2];
    f3  = in_instr[14:12];
    rs1 = in_instr[19:15];
    rs2 = in_instr[24:20];
    legal = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (opc)
        OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
        OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
    is_shift = (opc == OPC_OP_IMM) && (f3 == 3'b001 || f3 == 3'b101);
    op1 = (rs1 == 5'd0) ? '0 : (wr_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
    op2 = (rs2 == 5'd0) ? '0 : (wr_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  always_comb begin
    valid_d   = valid_q;
    type_d    = type_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rrs1_d    = rrs1_q;
    rrs2_d    = rrs2_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d   = 1'b1;
      type_d    = opc;
      funct3_d  = f3;
      funct7_d  = (legal && (opc == OPC_OP || is_shift)) ? in_instr[31:25] : 7'd0;
      rd_d      = (!legal || opc == OPC_STORE || opc == OPC_BRANCH) ? 5'd0 : in_instr[11:7];
      rs1_d     = rs1;
      rs2_d     = rs2;
      rrs1_d    = op1;
      rrs2_d    = op2;
      imm_d     = imm_decode(in_instr, legal);
      pc_d      = in_pc;
      illegal_d = !legal;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled bundle tracks writebacks to its source registers
      if (wr_en && wb_rd == rs1_q) rrs1_d = wb_data;
      if (wr_en && wb_rd == rs2_q) rrs2_d = wb_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      valid_q   <= 1'b0;
      type_q    <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rrs1_q    <= '0;
      rrs2_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
      valid_q   <= valid_d;
      type_q    <= type_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rrs1_q    <= rrs1_d;
      rrs2_q    <= rrs2_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_instr_type = type_q;
  assign out_funct3     = funct3_q;
  assign out_funct7     = funct7_q;
  assign out_rd         = rd_q;
  assign out_rrs1       = rrs1_q;
  assign out_rrs2       = rrs2_q;
  assign out_imm        = imm_q;
  assign out_pc         = pc_q;
  assign out_illegal    = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction sequence, a register-level model checked
// every cycle, and hand-computed literal expectations at key points.
module tb_decode_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_instr_type;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [31:0] out_rrs1, out_rrs2, out_imm, out_pc;
  logic        out_illegal;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr_type(out_instr_type),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rrs1(out_rrs1), .out_rrs2(out_rrs2), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: architectural register contents plus the bundle execute should be seeing
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_type, m_rd, m_rs1, m_rs2;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [31:0] m_rrs1, m_rrs2, m_imm, m_pc;
  logic        m_ill;

  function automatic logic [31:0] m_immediate(input logic [31:0] ins);
    logic signed [31:0] s;
    s = $signed(ins);
    case (ins[6:2])
      5'b00000, 5'b11001: return 32'(s >>> 20);
      5'b00100: return (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? (ins >> 20) & 32'h1F
                                                                       : 32'(s >>> 20);
      5'b01000: return (32'(s >>> 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
      5'b11000: return (32'(s >>> 19) & 32'hFFFFF000) | ((ins >> 20) & 32'h7E0)
                       | ((ins >> 7) & 32'h1E) | ((ins << 4) & 32'h800);
      5'b01101, 5'b00101: return ins & 32'hFFFFF000;
      5'b11011: return (32'(s >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000)
                       | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return 1'b0;
    case (ins[6:2])
      5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
      5'b01101, 5'b11000, 5'b11001, 5'b11011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare current outputs, then advance the model with the inputs the next edge will sample
  always @(negedge CLK) begin
    bit acc, lg, shf;
    if (cmp_en) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("type", out_instr_type, m_type);
        chk("funct3", out_funct3, m_f3);
        chk("funct7", out_funct7, m_f7);
        chk("rd", out_rd, m_rd);
        chk("rrs1", out_rrs1, m_rrs1);
        chk("rrs2", out_rrs2, m_rrs2);
        chk("imm", out_imm, m_imm);
        chk("pc", out_pc, m_pc);
        chk("illegal", out_illegal, m_ill);
      end
    end
    if (RST) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_valid = 1'b0;
      {m_type, m_rd, m_rs1, m_rs2, m_f3, m_f7, m_ill} = '0;
      {m_rrs1, m_rrs2, m_imm, m_pc} = '0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (acc) begin
        lg  = m_legal(in_instr);
        shf = in_instr[6:2] == 5'b00100 && (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101);
        m_valid = 1'b1;
        m_type  = in_instr[6:2];
        m_f3    = in_instr[14:12];
        m_f7    = (lg && (in_instr[6:2] == 5'b01100 || shf)) ? in_instr[31:25] : 7'd0;
        m_rd    = (!lg || in_instr[6:2] == 5'b01000 || in_instr[6:2] == 5'b11000) ? 5'd0 : in_instr[11:7];
        m_rs1   = in_instr[19:15];
        m_rs2   = in_instr[24:20];
        m_rrs1  = m_regs[m_rs1];
        m_rrs2  = m_regs[m_rs2];
        m_imm   = lg ? m_immediate(in_instr) : 32'h0;
        m_pc    = in_pc;
        m_ill   = !lg;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        m_rrs1 = m_regs[m_rs1];
        m_rrs2 = m_regs[m_rs2];
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    wb_en     = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h0;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD; out_ready = 1'b1;
    tick(); tick();
    RST = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_pc", out_pc, 32'h0);

    // addi x1,x0,-5
    send(32'hFFB00093, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_type", out_instr_type, 5'b00100);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_rrs1", out_rrs1, 32'h0);
    chk("addi_ill", out_illegal, 1'b0);
    chk("addi_pc", out_pc, 32'h100);

    // x2 = 0x80000000, then srai x3,x2,4
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h80000000;
    tick();
    wb_en = 1'b0;
    send(32'h40415193, 32'h104);
    tick();
    in_valid = 1'b0;
    chk("srai_f7", out_funct7, 7'h20);
    chk("srai_imm", out_imm, 32'h4);
    chk("srai_rrs1", out_rrs1, 32'h80000000);

    // add x6,x5,x5 while x5 is being written the same cycle
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    send(32'h00528333, 32'h108);
    tick();
    chk("byp_rrs1", out_rrs1, 32'h1234);
    chk("byp_rrs2", out_rrs2, 32'h1234);
    chk("byp_f7", out_funct7, 7'h0);
    drain();

    // sub x7,x5,x6 stalled, then x6 written while held
    out_ready = 1'b0;
    send(32'h406283B3, 32'h10C);
    tick();
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_rrs2_old", out_rrs2, 32'h0);
    send(32'h00000013, 32'h110);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'hAA;
    tick();
    chk("hold_rrs2", out_rrs2, 32'hAA);
    chk("hold_rrs1", out_rrs1, 32'h1234);
    chk("hold_rd", out_rd, 5'd7);
    chk("hold_f7", out_funct7, 7'h20);
    chk("hold_pc", out_pc, 32'h10C);
    chk("hold_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("release_valid", out_valid, 1'b0);

    // x0 writes are dropped, including the bypass path
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    send(32'h00000093, 32'h114);
    tick();
    chk("x0_rrs1", out_rrs1, 32'h0);
    wb_en = 1'b0;

    // Back-to-back: illegal encodings then each immediate format
    send(32'h0000007F, 32'h118);
    tick();
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_rd", out_rd, 5'd0);
    chk("ill_imm", out_imm, 32'h0);
    send(32'hFFB00090, 32'h11C);
    tick();
    chk("ill2_flag", out_illegal, 1'b1);
    chk("ill2_imm", out_imm, 32'h0);
    send(32'hFE512E23, 32'h120);
    tick();
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_rd", out_rd, 5'd0);
    chk("sw_rrs2", out_rrs2, 32'h1234);
    send(32'hFE000CE3, 32'h124);
    tick();
    chk("beq_imm", out_imm, 32'hFFFFFFF8);
    send(32'h12345537, 32'h128);
    tick();
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rd", out_rd, 5'd10);
    send(32'h008000EF, 32'h12C);
    tick();
    chk("jal_imm", out_imm, 32'h8);
    chk("jal_rd", out_rd, 5'd1);
    drain();

    // Reset while a bundle is stalled
    out_ready = 1'b0;
    send(32'h00528333, 32'h200);
    tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_rrs1", out_rrs1, 32'h0);
    out_ready = 1'b1;
    send(32'h00528333, 32'h204);
    tick();
    chk("post_rst_rrs1", out_rrs1, 32'h0);
    chk("post_rst_valid", out_valid, 1'b1);
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode and operand-fetch stage of the RV32I core. It is the producer side of the ALU interface.
- Accepts a fetched instruction with valid/ready and decodes it into instr_type/funct3/funct7/imm.
- Reads rs1/rs2 from an internal 32x32 register file, with writeback bypass.
- Presents registered operands to the ALU/execute stage through a valid/ready output register.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, register file depth (x0 hardwired zero)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
wb_en  in  1  register write strobe
wb_rd  in  5  write index
wb_data  in  32  write data
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_instr_type  out  5  in_instr[6:2]
out_funct3  out  3  in_instr[14:12]
out_funct7  out  7  in_instr[31:25] for OP and OP_IMM shifts (funct3 001/101), else 0
out_rd  out  5  destination; 0 for STORE/BRANCH
out_rrs1  out  32  rs1 value
out_rrs2  out  32  rs2 value
out_imm  out  32  decoded immediate
out_pc  out  32  registered in_pc
out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (RST=1 at posedge):
  - out_valid=0; all out_* data fields=0.
  - All 32 register file entries cleared to 0.
  - RST asserted mid-stall drops the held bundle. No handshake completes in a reset cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The bundle is registered and out_valid=1 on the next cycle (latency 1).
  - out_valid is held, with fields stable, while out_ready=0, except for the hold-update rule below.
  - out_valid falls when accepted with no new input. Back-to-back throughput is 1 per cycle.
- Supported instr_type values:
  - LOAD 00000, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011.
  - Any other value, or in_instr[1:0]!=11, gives out_illegal=1, imm=0 and rd=0. The bundle still passes the handshake.
- Immediate formats (all sign-extended from bit 31 unless noted):
  - I: LOAD, JALR, OP_IMM non-shift.
  - OP_IMM shifts (funct3 001/101): {27'b0, instr[24:20]}.
  - S: STORE. B: BRANCH, bit0=0. U: LUI/AUIPC, low 12 bits zero. J: JAL, bit0=0. OP: imm=0.
- Register file:
  - Writes occur at posedge when wb_en && wb_rd!=0. Writes to x0 are ignored, and x0 always reads 0.
  - Writes are independent of handshake state and also occur while RST is low.
- Read bypass: at acceptance, if wb_en && wb_rd!=0 && wb_rd==rs, the operand takes wb_data. rs1 and rs2 are bypassed independently.
- Hold-update: while out_valid && !out_ready, a write (wb_en, wb_rd!=0) matching the held rs1 or rs2 index replaces out_rrs1/out_rrs2 on the next cycle. Held rs indices are stored internally for this purpose.
- Simultaneous accept-out and accept-in: the new bundle loads, and bypass applies to the new bundle only.

Test Plan:
- addi x1,x0,-5 (0xFFB00093), out_ready=1: next cycle out_valid=1, type=00100, funct3=0, rd=1, imm=0xFFFFFFFB, rrs1=0, illegal=0.
- srai x3,x2,4 (0x40415193) after writing x2=0x80000000: funct7=0x20, imm=0x00000004, rrs1=0x80000000.
- Same-cycle bypass: wb_en=1, rd=5, data=0x1234 while accepting add x6,x5,x5 (0x00528333): rrs1=rrs2=0x1234, funct7=0.
- Stall: out_ready=0 holding sub x7,x5,x6 (0x406283B3), then wb x6=0xAA: next cycle rrs2=0xAA, other fields unchanged, in_ready=0. Then out_ready=1 completes in 1 cycle.
- Write to x0: wb rd=0 data=0xFFFF, then addi x1,x0,0: rrs1=0. Encoding 0x0000007F: illegal=1, rd=0, imm=0.
- RST pulse while out_valid=1 and out_ready=0: next cycle out_valid=0, in_ready=1, all registers read 0.
